// File: rtl/ipv4_pkg.sv
// Shared IPv4 header constants and receiver FSM encoding.
package ipv4_pkg;

  localparam logic [3:0] IPV4_VERSION  = 4'd4;
  localparam logic [3:0] IHL_MIN       = 4'd5;
  localparam logic [5:0] HDR_MIN_BYTES = 6'd20;

  localparam logic [5:0] OFS_TLEN  = 6'd2;
  localparam logic [5:0] OFS_TTL   = 6'd8;
  localparam logic [5:0] OFS_PROTO = 6'd9;
  localparam logic [5:0] OFS_SRC   = 6'd12;
  localparam logic [5:0] OFS_DST   = 6'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    OPT  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ipv4_hdr_rx_if.sv
// Byte-stream input and decoded-header result bundle of the IPv4 header receiver.
interface ipv4_hdr_rx_if;

  logic        in_valid;
  logic        in_sop;
  logic [7:0]  in_data;

  logic        hdr_done;
  logic        hdr_ok;
  logic        err_ver;
  logic        err_ihl;
  logic        err_len;
  logic        err_csum;
  logic        err_ttl;
  logic        err_trunc;
  logic [3:0]  ihl;
  logic [15:0] total_len;
  logic [7:0]  ttl;
  logic [7:0]  protocol;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;

  modport master (
    output in_valid, in_sop, in_data,
    input  hdr_done, hdr_ok, err_ver, err_ihl, err_len, err_csum, err_ttl, err_trunc,
    input  ihl, total_len, ttl, protocol, src_ip, dst_ip
  );

  modport slave (
    input  in_valid, in_sop, in_data,
    output hdr_done, hdr_ok, err_ver, err_ihl, err_len, err_csum, err_ttl, err_trunc,
    output ihl, total_len, ttl, protocol, src_ip, dst_ip
  );

endinterface

// File: rtl/ipv4_csum_acc.sv
// Byte-fed 16-bit ones-complement accumulator with end-around carry on every word.
module ipv4_csum_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        odd,
  input  logic [7:0]  data,
  output logic [15:0] sum
);

  logic [15:0] sum_q;
  logic [15:0] base;
  logic [7:0]  hi_q;
  logic [16:0] wide;

  // clr restarts the sum in the same cycle a new first byte may be loaded
  always_comb begin
    base = clr ? 16'd0 : sum_q;
    wide = {1'b0, base} + {1'b0, hi_q, data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      hi_q  <= '0;
    end else begin
      if (en && odd)
        sum_q <= wide[15:0] + {15'd0, wide[16]};
      else if (clr)
        sum_q <= '0;
      if (en && !odd)
        hi_q <= data;
      else if (clr)
        hi_q <= '0;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/ipv4_hdr_rx.sv
// Byte-serial IPv4 header receiver: field capture, option skip, checksum and sanity flags.
module ipv4_hdr_rx
  import ipv4_pkg::*;
#(
  parameter bit         CHECK_CSUM = 1'b1,
  parameter logic [7:0] MIN_TTL    = 8'd1
) (
  input logic          clk,
  input logic          reset,
  ipv4_hdr_rx_if.slave bus
);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, byte_idx, last_idx;
  logic        start, in_hdr, accept, trunc_q, done, csum_ok;
  logic [3:0]  version_q, ihl_q, ihl_eff;
  logic [15:0] tlen_q, csum_sum;
  logic [7:0]  ttl_q, proto_q;
  logic [31:0] src_q, dst_q;

  // a sop byte always restarts at index 0, whatever state we are in
  always_comb begin
    start    = bus.in_valid & bus.in_sop;
    in_hdr   = (state_q == HDR) || (state_q == OPT);
    accept   = bus.in_valid & (start | in_hdr);
    byte_idx = start ? 6'd0 : cnt_q;
    ihl_eff  = (ihl_q < IHL_MIN) ? IHL_MIN : ihl_q;
    last_idx = {ihl_eff, 2'b00} - 6'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = HDR;
      HDR: begin
        if (start)
          state_d = HDR;
        else if (accept && byte_idx == HDR_MIN_BYTES - 6'd1)
          state_d = (ihl_eff > IHL_MIN) ? OPT : DONE;
      end
      OPT: begin
        if (start)
          state_d = HDR;
        else if (accept && byte_idx == last_idx)
          state_d = DONE;
      end
      DONE:    state_d = start ? HDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trunc_q <= start & in_hdr;
      if (accept)
        cnt_q <= byte_idx + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      version_q <= '0;
      ihl_q     <= '0;
      tlen_q    <= '0;
      ttl_q     <= '0;
      proto_q   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
    end else if (accept) begin
      case (byte_idx)
        6'd0:            {version_q, ihl_q} <= bus.in_data;
        OFS_TLEN:        tlen_q[15:8] <= bus.in_data;
        OFS_TLEN + 6'd1: tlen_q[7:0]  <= bus.in_data;
        OFS_TTL:         ttl_q        <= bus.in_data;
        OFS_PROTO:       proto_q      <= bus.in_data;
        default: begin
          if (byte_idx >= OFS_SRC && byte_idx < OFS_DST)
            src_q <= {src_q[23:0], bus.in_data};
          else if (byte_idx >= OFS_DST && byte_idx < HDR_MIN_BYTES)
            dst_q <= {dst_q[23:0], bus.in_data};
        end
      endcase
    end
  end

  ipv4_csum_acc u_csum (
    .clk   (clk),
    .rst_n (reset),
    .clr   (start),
    .en    (accept),
    .odd   (byte_idx[0]),
    .data  (bus.in_data),
    .sum   (csum_sum)
  );

  assign csum_ok = (csum_sum == 16'hFFFF);
  // flags are gated by the done pulse so they read 0 outside it, including after reset
  assign done    = (state_q == DONE) | trunc_q;

  assign bus.hdr_done  = done;
  assign bus.err_ver   = done & (version_q != IPV4_VERSION);
  assign bus.err_ihl   = done & (ihl_q < IHL_MIN);
  assign bus.err_len   = done & (tlen_q < {10'd0, ihl_q, 2'b00});
  assign bus.err_csum  = done & CHECK_CSUM & ~csum_ok;
  assign bus.err_ttl   = done & (ttl_q < MIN_TTL);
  assign bus.err_trunc = trunc_q;
  assign bus.hdr_ok    = done & ~|{bus.err_ver, bus.err_ihl, bus.err_len,
                                   bus.err_csum, bus.err_ttl, bus.err_trunc};

  assign bus.ihl       = ihl_q;
  assign bus.total_len = tlen_q;
  assign bus.ttl       = ttl_q;
  assign bus.protocol  = proto_q;
  assign bus.src_ip    = src_q;
  assign bus.dst_ip    = dst_q;

endmodule

// File: tb/tb_ipv4_hdr_rx.sv
// Directed bench for ipv4_hdr_rx; a second instance with CHECK_CSUM=0 sees the same stream.
module tb_ipv4_hdr_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ipv4_hdr_rx_if bus ();
  ipv4_hdr_rx_if bus2 ();

  assign bus2.in_valid = bus.in_valid;
  assign bus2.in_sop   = bus.in_sop;
  assign bus2.in_data  = bus.in_data;

  ipv4_hdr_rx #(.CHECK_CSUM(1'b1), .MIN_TTL(8'd1)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  ipv4_hdr_rx #(.CHECK_CSUM(1'b0), .MIN_TTL(8'd1)) dut_nocs (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [7:0] REF_HDR [0:19] = '{
    8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
    8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};

  logic [7:0] pkt [0:59];

  function automatic logic [63:0] errs(input int sel);
    if (sel == 1)
      return 64'({bus2.err_ver, bus2.err_ihl, bus2.err_len, bus2.err_csum, bus2.err_ttl, bus2.err_trunc});
    return 64'({bus.err_ver, bus.err_ihl, bus.err_len, bus.err_csum, bus.err_ttl, bus.err_trunc});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_ref();
    for (int i = 0; i < 20; i++) pkt[i] = REF_HDR[i];
  endtask

  task automatic drive(input logic [7:0] d, input logic sop);
    bus.in_valid = 1'b1;
    bus.in_sop   = sop;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk("idle_no_done", 64'(bus.hdr_done), 64'd0);
    end
  endtask

  // send pkt[0..n-1]; with gaps, random bytes are followed by 1-3 idle cycles
  task automatic send_pkt(input int n, input bit gaps, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(pkt[i], i == 0);
      if (i != n - 1) begin
        chk({tag, "_early_done"}, 64'(bus.hdr_done), 64'd0);
        if (gaps && $urandom_range(1, 0) == 1)
          idle(int'($urandom_range(3, 1)));
      end
    end
    chk({tag, "_done"}, 64'(bus.hdr_done), 64'd1);
  endtask

  task automatic chk_ref_fields(input string tag);
    chk({tag, "_ihl"},   64'(bus.ihl),       64'h5);
    chk({tag, "_tlen"},  64'(bus.total_len), 64'h0073);
    chk({tag, "_ttl"},   64'(bus.ttl),       64'h40);
    chk({tag, "_proto"}, 64'(bus.protocol),  64'h11);
    chk({tag, "_src"},   64'(bus.src_ip),    64'hC0A80001);
    chk({tag, "_dst"},   64'(bus.dst_ip),    64'hC0A800C7);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_data  = 8'h00;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done",  64'(bus.hdr_done), 64'd0);
    chk("rst_ok",    64'(bus.hdr_ok),   64'd0);
    chk("rst_errs",  errs(0),           64'd0);
    chk("rst_ihl",   64'(bus.ihl),      64'd0);
    chk("rst_tlen",  64'(bus.total_len), 64'd0);
    chk("rst_src",   64'(bus.src_ip),   64'd0);
    rst_n = 1'b1;
    idle(2);

    // reference header, contiguous
    load_ref();
    send_pkt(20, 1'b0, "ref");
    chk("ref_ok",   64'(bus.hdr_ok), 64'd1);
    chk("ref_errs", errs(0),         64'd0);
    chk_ref_fields("ref");
    idle(1);
    chk("ref_hold_src", 64'(bus.src_ip), 64'hC0A80001);
    idle(1);

    // corrupted checksum byte
    load_ref();
    pkt[11] = 8'h62;
    send_pkt(20, 1'b0, "bad");
    chk("bad_errs",     errs(0),          64'b000100);
    chk("bad_ok",       64'(bus.hdr_ok),  64'd0);
    chk("bad_nocs_ok",  64'(bus2.hdr_ok), 64'd1);
    chk("bad_nocs_err", errs(1),          64'd0);
    idle(2);

    // ihl=6 with one option word
    load_ref();
    pkt[0] = 8'h46; pkt[10] = 8'hB5; pkt[11] = 8'h5F;
    for (int i = 20; i < 24; i++) pkt[i] = 8'h01;
    send_pkt(24, 1'b0, "opt");
    chk("opt_ok",   64'(bus.hdr_ok), 64'd1);
    chk("opt_ihl",  64'(bus.ihl),    64'h6);
    chk("opt_dst",  64'(bus.dst_ip), 64'hC0A800C7);
    idle(2);

    // idle gaps inside the header
    load_ref();
    send_pkt(20, 1'b1, "gap");
    chk("gap_ok", 64'(bus.hdr_ok), 64'd1);
    chk_ref_fields("gap");
    idle(2);

    // new sop at byte 10 aborts, then a full header follows
    load_ref();
    for (int i = 0; i < 10; i++) begin
      drive(pkt[i], i == 0);
      chk("trunc_pre_done", 64'(bus.hdr_done), 64'd0);
    end
    drive(pkt[0], 1'b1);
    chk("trunc_done",  64'(bus.hdr_done),  64'd1);
    chk("trunc_flag",  64'(bus.err_trunc), 64'd1);
    chk("trunc_ok",    64'(bus.hdr_ok),    64'd0);
    for (int i = 1; i < 20; i++) begin
      drive(pkt[i], 1'b0);
      if (i < 19) chk("trunc2_early_done", 64'(bus.hdr_done), 64'd0);
    end
    chk("trunc2_done", 64'(bus.hdr_done), 64'd1);
    chk("trunc2_ok",   64'(bus.hdr_ok),   64'd1);
    chk("trunc2_errs", errs(0),           64'd0);
    chk_ref_fields("trunc2");
    idle(2);

    // version 6, checksum adjusted
    load_ref();
    pkt[0] = 8'h65; pkt[10] = 8'h98;
    send_pkt(20, 1'b0, "ver");
    chk("ver_errs", errs(0),         64'b100000);
    chk("ver_ok",   64'(bus.hdr_ok), 64'd0);
    idle(2);

    // total_len 16 < 20, checksum adjusted
    load_ref();
    pkt[3] = 8'h10; pkt[11] = 8'hC4;
    send_pkt(20, 1'b0, "len");
    chk("len_errs", errs(0),            64'b001000);
    chk("len_tlen", 64'(bus.total_len), 64'h0010);
    idle(2);

    // ttl 0 below MIN_TTL, checksum adjusted
    load_ref();
    pkt[8] = 8'h00; pkt[10] = 8'hF8;
    send_pkt(20, 1'b0, "ttl");
    chk("ttl_errs",      errs(0),         64'b000010);
    chk("ttl_ok",        64'(bus.hdr_ok), 64'd0);
    chk("ttl_nocs_errs", errs(1),         64'b000010);
    idle(2);

    // ihl 4: flagged and treated as a 20-byte header
    load_ref();
    pkt[0] = 8'h44; pkt[10] = 8'hB9;
    send_pkt(20, 1'b0, "ihl");
    chk("ihl_errs", errs(0),      64'b010000);
    chk("ihl_ihl",  64'(bus.ihl), 64'h4);
    idle(2);

    // reset pulsed mid-header
    load_ref();
    for (int i = 0; i < 8; i++) drive(pkt[i], i == 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_done", 64'(bus.hdr_done),  64'd0);
    chk("mrst_errs", errs(0),            64'd0);
    chk("mrst_ihl",  64'(bus.ihl),       64'd0);
    chk("mrst_tlen", 64'(bus.total_len), 64'd0);
    chk("mrst_src",  64'(bus.src_ip),    64'd0);
    chk("mrst_dst",  64'(bus.dst_ip),    64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 8; i < 20; i++) begin
      drive(pkt[i], 1'b0);
      chk("mrst_no_done", 64'(bus.hdr_done), 64'd0);
    end
    idle(3);
    chk("mrst_src_after", 64'(bus.src_ip), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
